// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter: round-robin CPU/DMA arbiter and IDLE/ACCESS/RESP sequencer
// for the single-port RISC-SPM memory.                         Revision 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8,
  parameter int MAX_LOCK  = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDRWIDTH-1:0] cpu_addr_i,
  input  logic [DATAWIDTH-1:0] cpu_wdata_i,
  output logic [DATAWIDTH-1:0] cpu_rdata_o,
  output logic                 cpu_ack_o,
  input  logic                 dma_req_i,
  input  logic                 dma_we_i,
  input  logic [ADDRWIDTH-1:0] dma_addr_i,
  input  logic [DATAWIDTH-1:0] dma_wdata_i,
  output logic [DATAWIDTH-1:0] dma_rdata_o,
  output logic                 dma_ack_o,
  input  logic                 dma_lock_i,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  state_t                 state_q;
  logic                   grant_dma_q;
  logic                   last_dma_q;
  logic [7:0]             lock_cnt_q;
  logic [7:0]             lock_cnt_d;
  logic                   mem_en_q;
  logic                   cpu_ack_q;
  logic                   dma_ack_q;
  logic [DATAWIDTH-1:0]   cpu_rdata_q;
  logic [DATAWIDTH-1:0]   dma_rdata_q;
  logic [ADDRWIDTH-1:0]   addr_hold_q;
  logic [DATAWIDTH-1:0]   wdata_hold_q;

  logic                   lock_open;
  logic                   dma_wins;
  logic                   any_req;
  logic                   sel_we;
  logic [ADDRWIDTH-1:0]   sel_addr;
  logic [DATAWIDTH-1:0]   sel_wdata;

  // DMA keeps the port on a tie only while its burst lock has budget left.
  assign lock_open = dma_lock_i && (lock_cnt_q < LOCK_MAX);
  assign dma_wins  = dma_req_i && (!cpu_req_i || !last_dma_q || lock_open);
  assign any_req   = cpu_req_i || dma_req_i;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!cpu_req_i) begin
      lock_cnt_d = '0;
    end else if (dma_wins) begin
      if (lock_cnt_q < LOCK_MAX) lock_cnt_d = lock_cnt_q + 8'd1;
    end else begin
      lock_cnt_d = '0;
    end
  end

  // Requester inputs are only looked at while the access is in flight.
  assign sel_we    = grant_dma_q ? dma_we_i    : cpu_we_i;
  assign sel_addr  = grant_dma_q ? dma_addr_i  : cpu_addr_i;
  assign sel_wdata = grant_dma_q ? dma_wdata_i : cpu_wdata_i;

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_en_q && sel_we;
  assign mem_addr_o  = mem_en_q ? sel_addr  : addr_hold_q;
  assign mem_wdata_o = mem_en_q ? sel_wdata : wdata_hold_q;

  assign cpu_ack_o   = cpu_ack_q;
  assign dma_ack_o   = dma_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= IDLE;
      grant_dma_q  <= 1'b0;
      last_dma_q   <= 1'b1;
      lock_cnt_q   <= '0;
      mem_en_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          lock_cnt_q <= lock_cnt_d;
          if (any_req) begin
            state_q     <= ACCESS;
            grant_dma_q <= dma_wins;
            last_dma_q  <= dma_wins;
            mem_en_q    <= 1'b1;
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          mem_en_q     <= 1'b0;
          addr_hold_q  <= sel_addr;
          wdata_hold_q <= sel_wdata;
          if (grant_dma_q) begin
            dma_ack_q <= 1'b1;
            if (!dma_we_i) dma_rdata_q <= mem_rdata_i;
          end else begin
            cpu_ack_q <= 1'b1;
            if (!cpu_we_i) cpu_rdata_q <= mem_rdata_i;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          mem_en_q  <= 1'b0;
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural
// memory and per-port req/ack drivers.                         Revision 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       drop;
  } txn_t;

  typedef struct packed {
    logic       dma;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       cpu_req, cpu_we, cpu_ack;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dma_req, dma_we, dma_ack, dma_lock;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  txn_t       cpu_q[$];
  txn_t       dma_q[$];
  exp_t       exp_acc[$];
  exp_t       exp_ack[$];

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         prev_cyc = 0;
  logic       have_prev = 1'b0;
  logic       prev_ack = 1'b0;
  logic       gap_en = 1'b0;
  logic [7:0] cpu_model = 8'h00;
  logic [7:0] dma_model = 8'h00;

  mem_port_arbiter #(.DATAWIDTH(8), .ADDRWIDTH(8), .MAX_LOCK(4)) dut (
    .clk(clk), .clr(clr),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_rdata_o(dma_rdata), .dma_ack_o(dma_ack),
    .dma_lock_i(dma_lock),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  initial begin : memory
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Requester drivers: present the queue head, pop it on ack.
  initial begin : cpu_drv
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (cpu_ack && cpu_q.size() > 0) void'(cpu_q.pop_front());
      if (cpu_q.size() == 0) cpu_req = 1'b0;
      else if (cpu_q[0].drop && mem_en) cpu_req = 1'b0;
      else begin
        cpu_req = 1'b1; cpu_we = cpu_q[0].we;
        cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].data;
      end
    end
  end

  initial begin : dma_drv
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (dma_ack && dma_q.size() > 0) void'(dma_q.pop_front());
      if (dma_q.size() == 0) dma_req = 1'b0;
      else begin
        dma_req = 1'b1; dma_we = dma_q[0].we;
        dma_addr = dma_q[0].addr; dma_wdata = dma_q[0].data;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!gap_en) have_prev = 1'b0;
      if (mem_en) begin
        if (exp_acc.size() == 0) fail("acc_unexpected");
        else begin
          e = exp_acc.pop_front();
          chk("acc_we", 32'(mem_we), 32'(e.we));
          chk("acc_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) chk("acc_wdata", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (cpu_ack || dma_ack) begin
        chk("ack_both", 32'(cpu_ack && dma_ack), 32'd0);
        chk("ack_repeat", 32'(prev_ack), 32'd0);
        if (have_prev) chk("ack_gap", 32'(cyc - prev_cyc), 32'd3);
        have_prev = gap_en;
        prev_cyc  = cyc;
        if (exp_ack.size() == 0) fail("ack_unexpected");
        else begin
          e = exp_ack.pop_front();
          chk("ack_port", 32'(dma_ack), 32'(e.dma));
          if (!e.we) begin
            if (e.dma) dma_model = e.data;
            else       cpu_model = e.data;
          end
          chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_model));
          chk("dma_rdata", 32'(dma_rdata), 32'(dma_model));
        end
      end
      prev_ack = cpu_ack || dma_ack;
    end
  end

  task automatic add_txn(input logic dma, input logic we, input logic [7:0] addr,
                         input logic [7:0] data, input logic drop);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data; t.drop = drop;
    if (dma) dma_q.push_back(t);
    else     cpu_q.push_back(t);
  endtask

  // Expected grant in arbitration order; data is the read result for reads.
  task automatic exp_txn(input logic dma, input logic we, input logic [7:0] addr,
                         input logic [7:0] data);
    exp_t e;
    e.dma = dma; e.we = we; e.addr = addr; e.data = data;
    exp_acc.push_back(e);
    exp_ack.push_back(e);
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while ((cpu_q.size() + dma_q.size() + exp_acc.size() + exp_ack.size()) != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) fail("timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    cpu_model = 8'h00;
    dma_model = 8'h00;
    repeat (2) @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    clr = 1'b0;
    dma_lock = 1'b0;
    #3;
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Simultaneous requests out of reset: CPU wins the first tie.
    gap_en = 1'b1;
    add_txn(1'b0, 1'b1, 8'h01, 8'hA1, 1'b0);
    add_txn(1'b1, 1'b1, 8'h02, 8'hB2, 1'b0);
    exp_txn(1'b0, 1'b1, 8'h01, 8'hA1);
    exp_txn(1'b1, 1'b1, 8'h02, 8'hB2);
    wait_done(40);
    gap_en = 1'b0;

    // CPU only: write then read back, with access latency checked directly.
    add_txn(1'b0, 1'b1, 8'h10, 8'h5A, 1'b0);
    add_txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    exp_txn(1'b0, 1'b1, 8'h10, 8'h5A);
    exp_txn(1'b0, 1'b0, 8'h10, 8'h5A);
    @(posedge clk);
    @(posedge clk); #2;
    chk("cpu_lat_en", 32'(mem_en), 32'd1);
    chk("cpu_lat_we", 32'(mem_we), 32'd1);
    wait_done(40);
    chk("addr_hold", 32'(mem_addr), 32'h10);

    // Both ports streaming, no lock: strict alternation 3 cycles apart.
    do_reset();
    gap_en = 1'b1;
    add_txn(1'b0, 1'b1, 8'h20, 8'hC0, 1'b0);
    add_txn(1'b0, 1'b1, 8'h21, 8'hC1, 1'b0);
    add_txn(1'b0, 1'b0, 8'h01, 8'h00, 1'b0);
    add_txn(1'b1, 1'b1, 8'h30, 8'hD0, 1'b0);
    add_txn(1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
    add_txn(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    exp_txn(1'b0, 1'b1, 8'h20, 8'hC0);
    exp_txn(1'b1, 1'b1, 8'h30, 8'hD0);
    exp_txn(1'b0, 1'b1, 8'h21, 8'hC1);
    exp_txn(1'b1, 1'b0, 8'h02, 8'hB2);
    exp_txn(1'b0, 1'b0, 8'h01, 8'hA1);
    exp_txn(1'b1, 1'b0, 8'h20, 8'hC0);
    wait_done(60);
    gap_en = 1'b0;

    // DMA burst lock, MAX_LOCK = 4, after one CPU grant.
    dma_lock = 1'b1;
    add_txn(1'b0, 1'b1, 8'h57, 8'h01, 1'b0);
    exp_txn(1'b0, 1'b1, 8'h57, 8'h01);
    wait_done(30);
    add_txn(1'b0, 1'b1, 8'h58, 8'h70, 1'b0);
    add_txn(1'b0, 1'b0, 8'h50, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) add_txn(1'b1, 1'b1, 8'(8'h50 + i), 8'(8'h60 + i), 1'b0);
    add_txn(1'b1, 1'b0, 8'h58, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) exp_txn(1'b1, 1'b1, 8'(8'h50 + i), 8'(8'h60 + i));
    exp_txn(1'b0, 1'b1, 8'h58, 8'h70);
    exp_txn(1'b1, 1'b1, 8'h54, 8'h64);
    exp_txn(1'b1, 1'b0, 8'h58, 8'h70);
    exp_txn(1'b0, 1'b0, 8'h50, 8'h60);
    wait_done(80);
    dma_lock = 1'b0;

    // DMA read leaves cpu_rdata alone; CPU read with req dropped in ACCESS.
    add_txn(1'b0, 1'b1, 8'h60, 8'h77, 1'b0);
    add_txn(1'b0, 1'b0, 8'h60, 8'h00, 1'b0);
    exp_txn(1'b0, 1'b1, 8'h60, 8'h77);
    exp_txn(1'b0, 1'b0, 8'h60, 8'h77);
    wait_done(30);
    add_txn(1'b1, 1'b1, 8'h61, 8'hC3, 1'b0);
    add_txn(1'b1, 1'b0, 8'h61, 8'h00, 1'b0);
    exp_txn(1'b1, 1'b1, 8'h61, 8'hC3);
    exp_txn(1'b1, 1'b0, 8'h61, 8'hC3);
    wait_done(30);
    add_txn(1'b0, 1'b0, 8'h61, 8'h00, 1'b1);
    exp_txn(1'b0, 1'b0, 8'h61, 8'hC3);
    wait_done(30);

    // Reset in the middle of a write access, then normal service afterwards.
    add_txn(1'b0, 1'b1, 8'h70, 8'h99, 1'b0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!mem_en && n < 20);
    chk("clr_pre_en", 32'(mem_en), 32'd1);
    #1;
    clr = 1'b0;
    cpu_model = 8'h00;
    dma_model = 8'h00;
    #1;
    chk("clr_mem_en", 32'(mem_en), 32'd0);
    chk("clr_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    chk("clr_no_ack", 32'(cpu_ack || dma_ack), 32'd0);
    exp_txn(1'b0, 1'b1, 8'h70, 8'h99);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("rel_mem_en", 32'(mem_en), 32'd1);
    chk("rel_mem_addr", 32'(mem_addr), 32'h70);
    @(posedge clk); #1;
    chk("rel_cpu_ack", 32'(cpu_ack), 32'd1);
    wait_done(30);
    add_txn(1'b0, 1'b0, 8'h70, 8'h00, 1'b0);
    exp_txn(1'b0, 1'b0, 8'h70, 8'h99);
    wait_done(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
